// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM encoding, sizing helpers and saturation limits for the FIR engine
package fir_pkg;

    typedef enum logic [1:0] {FSM_IDLE, FSM_MAC, FSM_ROUND, FSM_OUT} fsm_state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // headroom for N_TAPS full-scale products so the sum can never wrap
    function automatic int acc_width(input int data_w, input int coef_w, input int tap_w);
        return data_w + coef_w + tap_w;
    endfunction

    function automatic longint sat_max(input int data_w);
        return (longint'(1) <<< (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int data_w);
        return -(longint'(1) <<< (data_w - 1));
    endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// fir_mac_sat: registered multiply-accumulate with round-half-up, shift and saturate to DATA_W
module fir_mac_sat import fir_pkg::*; #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 32,
    parameter int COEF_FRAC = 16,
    parameter int ACC_W     = acc_width(16, 32, 5)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] h,
    output logic signed [DATA_W-1:0] res
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_W));

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [ACC_W-1:0]  sh;

    assign prod = PROD_W'(x) * PROD_W'(h);
    assign rnd  = acc + (ACC_W'(1) << (COEF_FRAC - 1));
    assign sh   = rnd >>> COEF_FRAC;
    assign res  = sh > SAT_HI ? SAT_HI[DATA_W-1:0] : sh < SAT_LO ? SAT_LO[DATA_W-1:0] : sh[DATA_W-1:0];

    // accumulator is cleared while idle and adds one tap product per enabled cycle
    always_ff @(posedge clk) begin
        if (!rstn || clr) acc <= '0;
        else if (en) acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/fir_stream_bank.sv
// fir_stream_bank: streaming FIR with shared sample history, loadable coefficient banks and bypass
module fir_stream_bank import fir_pkg::*; #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 32,
    parameter int COEF_FRAC = 16,
    parameter int N_TAPS    = 23,
    parameter int N_BANKS   = 4,
    parameter int TAP_W     = clog2(N_TAPS),
    parameter int BANK_W    = clog2(N_BANKS) < 1 ? 1 : clog2(N_BANKS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [BANK_W-1:0]        bank_sel,
    input  logic                     bypass,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     flush,
    input  logic                     coef_we,
    input  logic [BANK_W-1:0]        coef_bank,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     coef_ready,
    output logic                     coef_drop
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAP_W);
    localparam logic [TAP_W-1:0] LAST = TAP_W'(N_TAPS - 1);

    fsm_state_t               state;
    logic signed [DATA_W-1:0] hist [N_TAPS];
    logic signed [COEF_W-1:0] coef [N_BANKS][N_TAPS];
    logic [TAP_W-1:0]         wr_ptr;
    logic [TAP_W-1:0]         rd_ptr;
    logic [TAP_W-1:0]         tap;
    logic [BANK_W-1:0]        bank;
    logic signed [DATA_W-1:0] mac_res;
    logic                     coef_ok;

    assign in_ready   = state == FSM_IDLE && !flush;
    assign coef_ready = state == FSM_IDLE && !flush;
    assign out_valid  = state == FSM_OUT;
    assign coef_ok    = coef_ready && int'(coef_addr) < N_TAPS && int'(coef_bank) < N_BANKS;

    fir_mac_sat #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .COEF_FRAC(COEF_FRAC),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk (clk),
        .rstn(rstn),
        .clr (state == FSM_IDLE),
        .en  (state == FSM_MAC),
        .x   (hist[rd_ptr]),
        .h   (coef[bank][tap]),
        .res (mac_res)
    );

    // sequencer: accept a sample, walk taps newest-first, round, then hold the result until taken
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= FSM_IDLE;
            hist     <= '{default: '0};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tap      <= '0;
            bank     <= '0;
            out_data <= '0;
        end else begin
            case (state)
                FSM_IDLE: begin
                    if (flush) begin
                        hist   <= '{default: '0};
                        wr_ptr <= '0;
                    end else if (in_valid) begin
                        bank         <= bank_sel;
                        hist[wr_ptr] <= in_data;
                        rd_ptr       <= wr_ptr;
                        wr_ptr       <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
                        tap          <= '0;
                        if (bypass) out_data <= in_data;
                        state        <= bypass ? FSM_OUT : FSM_MAC;
                    end
                end
                FSM_MAC: begin
                    rd_ptr <= rd_ptr == '0 ? LAST : rd_ptr - 1'b1;
                    tap    <= tap + 1'b1;
                    if (tap == LAST) state <= FSM_ROUND;
                end
                FSM_ROUND: begin
                    out_data <= mac_res;
                    state    <= FSM_OUT;
                end
                default: if (out_ready) state <= FSM_IDLE;
            endcase
        end
    end

    // coefficient port: land legal idle-time writes, remember any refused write until reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            coef      <= '{default: '{default: '0}};
            coef_drop <= 1'b0;
        end else if (coef_we) begin
            if (coef_ok) coef[coef_bank][coef_addr] <= coef_data;
            else coef_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_stream_bank.sv
// tb_fir_stream_bank: scenario tasks checked against a direct convolution model of the filter
module tb_fir_stream_bank;

    localparam int DW = 16, CW = 32, FRAC = 16, NT = 23, NB = 4, TW = 5, BW = 2;

    logic                 clk = 0, rstn = 0, in_valid = 0, bypass = 0, out_ready = 1;
    logic                 flush = 0, coef_we = 0;
    logic                 in_ready, out_valid, coef_ready, coef_drop;
    logic signed [DW-1:0] in_data = '0;
    logic signed [DW-1:0] out_data;
    logic [BW-1:0]        bank_sel = '0, coef_bank = '0;
    logic [TW-1:0]        coef_addr = '0;
    logic [CW-1:0]        coef_data = '0;

    int     checks = 0, errors = 0;
    int     xs[$];
    longint hm[NB][NT];

    always #5 clk = ~clk;

    fir_stream_bank dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bank_sel(bank_sel), .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .coef_we(coef_we), .coef_bank(coef_bank),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready), .coef_drop(coef_drop)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // y[n] = sat(floor((sum_k x[n-k]*h[k] + 2^(FRAC-1)) / 2^FRAC)); xs[0] is the newest sample
    function automatic int model_out(input int b);
        longint acc = 0;
        for (int k = 0; k < xs.size(); k++) acc += longint'(xs[k]) * hm[b][k];
        acc = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    task automatic model_reset;
        xs.delete();
        for (int i = 0; i < NB; i++) for (int j = 0; j < NT; j++) hm[i][j] = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rstn = 0; in_valid = 0; coef_we = 0; flush = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        model_reset();
    endtask

    task automatic write_coef(input int b, input int a, input int d);
        @(negedge clk);
        coef_we = 1; coef_bank = BW'(b); coef_addr = TW'(a); coef_data = d;
        @(posedge clk);
        #1 coef_we = 0;
        if (a < NT) hm[b][a] = longint'(d);
    endtask

    task automatic do_flush;
        @(negedge clk);
        flush = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        checks++;
        if (coef_ready !== 1'b0) begin errors++; $display("FAIL flush_coef_ready got %b want 0", coef_ready); end
        @(posedge clk);
        #1 flush = 0;
        xs.delete();
    endtask

    task automatic send(input int s, input int b, input bit byp, input int hold, input bit disturb, output int got);
        int want, lat;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got %b want 1", in_ready); end
        in_valid = 1; in_data = DW'(s); bank_sel = BW'(b); bypass = byp; out_ready = (hold == 0);
        @(posedge clk);
        xs.push_front(s);
        if (xs.size() > NT) void'(xs.pop_back());
        want = byp ? s : model_out(b);
        #1 in_valid = 0; bank_sel = BW'($urandom); bypass = ~byp;
        lat = 1;
        if (disturb) begin
            @(negedge clk);
            checks++;
            if (coef_ready !== 1'b0) begin errors++; $display("FAIL busy_coef_ready got %b want 0", coef_ready); end
            coef_we = 1; coef_bank = BW'(b); coef_addr = '0; coef_data = $urandom; flush = 1;
            @(posedge clk);
            lat++;
            #1 coef_we = 0; flush = 0;
        end
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat !== (byp ? 1 : NT + 2)) begin errors++; $display("FAIL latency got %0d want %0d", lat, byp ? 1 : NT + 2); end
        got = out_data;
        checks++;
        if (got !== want) begin errors++; $display("FAIL result got %0d want %0d", got, want); end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; in_data = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(want) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure got valid=%b data=%0d in_ready=%b want 1/%0d/0", out_valid, out_data, in_ready, want);
            end
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_result got valid=%b want 0", out_valid); end
        if (disturb) begin
            checks++;
            if (coef_drop !== 1'b1) begin errors++; $display("FAIL busy_drop got %b want 1", coef_drop); end
        end
    endtask

    task automatic load_impulse;
        for (int k = 0; k < NT; k++) write_coef(0, k, (k + 1) << 16);
    endtask

    task automatic run_impulse(input string tag);
        int got;
        for (int k = 0; k < NT; k++) begin
            send(k == 0 ? 1000 : 0, 0, 0, 0, 0, got);
            checks++;
            if (got !== 1000 * (k + 1)) begin
                errors++;
                $display("FAIL %s_tap%0d got %0d want %0d", tag, k, got, 1000 * (k + 1));
            end
        end
    endtask

    task automatic test_reset;
        int got;
        do_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        checks++;
        if (coef_ready !== 1'b1) begin errors++; $display("FAIL reset_coef_ready got %b want 1", coef_ready); end
        checks++;
        if (coef_drop !== 1'b0) begin errors++; $display("FAIL reset_coef_drop got %b want 0", coef_drop); end
        send(1234, 0, 0, 0, 0, got);
        checks++;
        if (got !== 0) begin errors++; $display("FAIL reset_coefs_zero got %0d want 0", got); end
    endtask

    task automatic test_impulse;
        do_flush();
        load_impulse();
        run_impulse("impulse");
    endtask

    task automatic test_round_sat;
        int got;
        for (int k = 0; k < NT; k++) begin
            write_coef(1, k, 32'h8000);
            write_coef(2, k, 32'h10000);
        end
        do_flush();
        send(3, 1, 0, 0, 0, got);
        checks++;
        if (got !== 2) begin errors++; $display("FAIL round_pos got %0d want 2", got); end
        do_flush();
        send(-3, 1, 0, 0, 0, got);
        checks++;
        if (got !== -1) begin errors++; $display("FAIL round_neg got %0d want -1", got); end
        do_flush();
        repeat (NT) send(32767, 2, 0, 0, 0, got);
        checks++;
        if (got !== 32767) begin errors++; $display("FAIL sat_max got %0d want 32767", got); end
        repeat (NT) send(-32768, 2, 0, 0, 0, got);
        checks++;
        if (got !== -32768) begin errors++; $display("FAIL sat_min got %0d want -32768", got); end
    endtask

    task automatic test_bypass_bank;
        int got;
        send(32'h1234, 3, 1, 0, 0, got);
        checks++;
        if (got !== 32'h1234) begin errors++; $display("FAIL bypass got %0h want 1234", got); end
        for (int i = 0; i < 4; i++) send($urandom_range(0, 2000) - 1000, i % 3, 0, 0, 0, got);
    endtask

    task automatic test_backpressure;
        int got;
        send($urandom_range(0, 8000) - 4000, 1, 0, 10, 0, got);
        send($urandom_range(0, 8000) - 4000, 0, 1, 3, 0, got);
    endtask

    task automatic test_coef_protect;
        int got;
        do_reset();
        @(negedge clk);
        checks++;
        if (coef_drop !== 1'b0) begin errors++; $display("FAIL drop_cleared got %b want 0", coef_drop); end
        load_impulse();
        write_coef(0, NT, 32'h7fff0000);
        @(negedge clk);
        checks++;
        if (coef_drop !== 1'b1) begin errors++; $display("FAIL addr_range_drop got %b want 1", coef_drop); end
        do_reset();
        load_impulse();
        send(1000, 0, 0, 0, 1, got);
        checks++;
        if (got !== 1000) begin errors++; $display("FAIL busy_write_first got %0d want 1000", got); end
        send(1000, 0, 0, 0, 0, got);
        checks++;
        if (got !== 3000) begin errors++; $display("FAIL busy_write_kept got %0d want 3000", got); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clk);
        in_valid = 1; in_data = 500; bank_sel = '0; bypass = 0;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rstn = 0;
        @(posedge clk);
        #1 rstn = 1;
        model_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_output got %0d want 0", seen); end
        load_impulse();
        run_impulse("after_reset");
    endtask

    task automatic test_flush;
        int got;
        for (int i = 0; i < 5; i++) send($urandom_range(0, 20000) - 10000, 0, 0, 0, 0, got);
        do_flush();
        run_impulse("flush");
    endtask

    task automatic test_random;
        int got;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < NT; k++) write_coef(b, k, int'($urandom) >>> $urandom_range(4, 18));
        for (int i = 0; i < 40; i++)
            send(int'($signed(16'($urandom))), $urandom_range(0, NB - 1), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3), 0, got);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_round_sat();
        test_bypass_bank();
        test_backpressure();
        test_coef_protect();
        test_reset_mid();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
